// File: rtl/reg_file_wb.sv
// reg_file_wb: RV32I integer register file with write-first bypass
// and a per-register load-pending scoreboard for load-use stalls.
module reg_file_wb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  input  logic            wb_is_load,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic [CW-1:0]   pending_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            wb_we;
  logic            pend_set;
  logic            pend_clr;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            rs1_zero;
  logic            rs2_zero;
  logic            rs1_mask;
  logic            rs2_mask;

  assign wb_we    = wb_en & (wb_addr != '0);
  assign pend_set = ld_issue & (ld_rd != '0);
  assign pend_clr = wb_we & wb_is_load;

  assign rs1_zero = (rs1_addr == '0);
  assign rs2_zero = (rs2_addr == '0);
  assign rs1_hit  = wb_we & (wb_addr == rs1_addr);
  assign rs2_hit  = wb_we & (wb_addr == rs2_addr);

  // Register array: x0 is never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read port 1: x0 reads zero, same-cycle write-back wins over array.
  always_comb begin
    rs1_data = regs[rs1_addr];
    unique case (1'b1)
      rs1_zero: rs1_data = '0;
      rs1_hit:  rs1_data = wb_data;
      default:  rs1_data = regs[rs1_addr];
    endcase
  end

  // Read port 2: same rules, independent of port 1.
  always_comb begin
    rs2_data = regs[rs2_addr];
    unique case (1'b1)
      rs2_zero: rs2_data = '0;
      rs2_hit:  rs2_data = wb_data;
      default:  rs2_data = regs[rs2_addr];
    endcase
  end

  // Next pending vector: clear first so a younger load's set wins.
  always_comb begin
    pend_nxt = pend;
    if (pend_clr) begin
      pend_nxt[wb_addr] = 1'b0;
    end
    if (pend_set) begin
      pend_nxt[ld_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Population count of the next pending vector.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
    end
  end

  // Scoreboard and its count advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      pending_cnt <= '0;
    end else begin
      pend        <= pend_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  // A load completing this cycle is already bypassed, so it must not stall.
  assign rs1_mask    = wb_en & wb_is_load & (wb_addr == rs1_addr);
  assign rs2_mask    = wb_en & wb_is_load & (wb_addr == rs2_addr);
  assign rs1_pending = pend[rs1_addr] & ~rs1_mask;
  assign rs2_pending = pend[rs2_addr] & ~rs2_mask;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: scoreboard bench for reg_file_wb against a
// behavioural register/pending model.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        wb_is_load;
  logic        rs1_pending;
  logic        rs2_pending;
  logic [5:0]  pending_cnt;

  reg_file_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .wb_is_load (wb_is_load),
    .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        p1;
    logic        p2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];

  int unsigned m_regs [32];
  bit          m_pend [32];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
    return n;
  endfunction

  function automatic int unsigned m_read(input int a, input bit en,
                                         input int wa,
                                         input int unsigned wd);
    if (a == 0) return 0;
    if (en && wa == a) return wd;
    return m_regs[a];
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance model.
  task automatic step(input bit rn, input bit en, input int wa,
                      input int unsigned wd, input bit li,
                      input int lr, input bit wl,
                      input int a1, input int a2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rn;
    wb_en      = en;
    wb_addr    = 5'(wa);
    wb_data    = wd;
    ld_issue   = li;
    ld_rd      = 5'(lr);
    wb_is_load = wl;
    rs1_addr   = 5'(a1);
    rs2_addr   = 5'(a2);
    if (!rn) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 0;
        m_pend[i] = 0;
      end
    end
    e.d1  = m_read(a1, en, wa, wd);
    e.d2  = m_read(a2, en, wa, wd);
    e.p1  = m_pend[a1] && !(en && wl && wa == a1);
    e.p2  = m_pend[a2] && !(en && wl && wa == a2);
    e.cnt = 6'(m_count());
    q.push_back(e);
    if (rn) begin
      if (en && wa != 0) m_regs[wa] = wd;
      if (en && wl && wa != 0) m_pend[wa] = 0;
      if (li && lr != 0) m_pend[lr] = 1;
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data", rs1_data, e.d1);
      chk("rs2_data", rs2_data, e.d2);
      chk("rs1_pending", 32'(rs1_pending), 32'(e.p1));
      chk("rs2_pending", 32'(rs2_pending), 32'(e.p2));
      chk("pending_cnt", 32'(pending_cnt), 32'(e.cnt));
    end
  end

  initial begin
    rst_n = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ld_issue = 1'b0; ld_rd = '0; wb_is_load = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end

    // Reset: every address reads zero on both ports.
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, 0, i, 31 - i);

    // Write and read back; x0 ignores writes.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 5, 5);
    step(1, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle bypass on rs2 over an older value.
    step(1, 1, 7, 32'h11, 0, 0, 0, 0, 0);
    step(1, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 5, 7);
    step(1, 0, 0, 0, 0, 0, 0, 7, 7);

    // Load-use: issue, stall, clearing write-back masks the stall.
    step(1, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 3, 0);
    step(1, 1, 3, 32'hCAFE0003, 0, 0, 1, 3, 3);
    step(1, 0, 0, 0, 0, 0, 0, 3, 3);

    // Collision: set wins over clear on the same register; x0 never pends.
    step(1, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 1, 9, 32'h99, 1, 9, 1, 9, 0);
    step(1, 0, 0, 0, 1, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 9, 0);
    step(1, 1, 9, 32'h999, 1, 12, 1, 12, 9);
    step(1, 1, 12, 32'h12, 0, 0, 1, 12, 9);

    // Async reset between edges after pending x4 and writing x4.
    step(1, 1, 4, 32'h55, 1, 4, 0, 4, 4);
    step(1, 0, 0, 0, 0, 0, 0, 4, 4);
    step(0, 0, 0, 0, 0, 0, 0, 4, 4);
    step(1, 0, 0, 0, 0, 0, 0, 4, 4);
    step(1, 0, 0, 0, 0, 0, 0, 4, 0);

    // Randomized traffic; narrow address range forces collisions.
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = (n % 3 == 0) ? 3 : 31;
      step(1, 1'($urandom_range(0, 1)), $urandom_range(0, lim),
           $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, lim),
           1'($urandom_range(0, 1)), $urandom_range(0, lim),
           $urandom_range(0, lim));
    end

    @(posedge clk);
    #1;
    wb_en = 1'b0; ld_issue = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
